nios_sd_loader_cpu_mul_seq: RTL and testbench

NIOS_SD_LOADER_CPU_MUL_SEQ -- requirements
Module: nios_sd_loader_cpu_mul_seq

---
 rtl/nios_sd_loader_cpu_mul_seq.sv | 115 +++++++++++
 tb/tb_nios_sd_loader_cpu_mul_seq.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/nios_sd_loader_cpu_mul_seq.sv
// Sequencer for a 16x16 multiplier cell: MUL (low word) in 2 cell-cycles, MULXUU (high word, unsigned) in 4.
// Response valid 3 cycles after accept for MUL and 5 for MULXUU; one op in flight, result held until rsp_ready.
module nios_sd_loader_cpu_mul_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_op,
    input  logic [31:0] req_src1,
    input  logic [31:0] req_src2,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic [31:0] cell_src1,
    output logic [31:0] cell_src2,
    output logic        cell_en,
    input  logic [31:0] cell_p1,
    input  logic [31:0] cell_p2,
    input  logic [31:0] cell_p3,
    output logic [15:0] op_count
);

    typedef enum logic [2:0] {IDLE, ISSUE1, CAP1, ISSUE2, CAP2, RESP} state_t;

    state_t      state;
    logic [15:0] src1_hi;
    logic [15:0] src2_hi;
    logic        op;
    logic [31:0] lo;
    logic [32:0] mid;

    logic [32:0] mid_now;
    logic [31:0] low_now;
    logic [32:0] low_sum;
    logic [31:0] high_now;

    // Low operand halves go straight into cell_src at accept and stay there until
    // the next issue, so only the upper halves need their own copy for ISSUE2.
    always_comb begin
        mid_now  = {1'b0, cell_p2} + {1'b0, cell_p3};
        low_now  = cell_p1 + {mid_now[15:0], 16'h0};
        low_sum  = {1'b0, lo} + {1'b0, mid[15:0], 16'h0};
        high_now = cell_p1 + {15'h0, mid[32:16]} + {31'h0, low_sum[32]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_result <= 32'h0;
            cell_en    <= 1'b0;
            cell_src1  <= 32'h0;
            cell_src2  <= 32'h0;
            op_count   <= 16'h0;
            src1_hi    <= 16'h0;
            src2_hi    <= 16'h0;
            op         <= 1'b0;
            lo         <= 32'h0;
            mid        <= 33'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        src1_hi   <= req_src1[31:16];
                        src2_hi   <= req_src2[31:16];
                        op        <= req_op;
                        cell_src1 <= req_src1;
                        cell_src2 <= req_src2;
                        cell_en   <= 1'b1;
                        req_ready <= 1'b0;
                        state     <= ISSUE1;
                    end
                end
                ISSUE1: begin
                    cell_en <= 1'b0;
                    state   <= CAP1;
                end
                CAP1: begin
                    lo  <= cell_p1;
                    mid <= mid_now;
                    if (!op) begin
                        rsp_result <= low_now;
                        rsp_valid  <= 1'b1;
                        state      <= RESP;
                    end else begin
                        cell_src1 <= {16'h0, src1_hi};
                        cell_src2 <= {16'h0, src2_hi};
                        cell_en   <= 1'b1;
                        state     <= ISSUE2;
                    end
                end
                ISSUE2: begin
                    cell_en <= 1'b0;
                    state   <= CAP2;
                end
                CAP2: begin
                    rsp_result <= high_now;
                    rsp_valid  <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        op_count  <= op_count + 16'h1;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nios_sd_loader_cpu_mul_seq.sv
// Directed bench for nios_sd_loader_cpu_mul_seq with a registered 16x16 cell model.
module tb_nios_sd_loader_cpu_mul_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_op = 1'b0;
    logic [31:0] req_src1 = 32'h0;
    logic [31:0] req_src2 = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_result;
    logic [31:0] cell_src1;
    logic [31:0] cell_src2;
    logic        cell_en;
    logic [31:0] cell_p1 = 32'h0;
    logic [31:0] cell_p2 = 32'h0;
    logic [31:0] cell_p3 = 32'h0;
    logic [15:0] op_count;

    int errors = 0;
    int checks = 0;
    int exp_count = 0;

    always #5 clk = ~clk;

    nios_sd_loader_cpu_mul_seq dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_src1   (req_src1),
        .req_src2   (req_src2),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .cell_src1  (cell_src1),
        .cell_src2  (cell_src2),
        .cell_en    (cell_en),
        .cell_p1    (cell_p1),
        .cell_p2    (cell_p2),
        .cell_p3    (cell_p3),
        .op_count   (op_count)
    );

    always @(posedge clk) begin
        if (cell_en) begin
            cell_p1 <= {16'h0, cell_src1[15:0]} * {16'h0, cell_src2[15:0]};
            cell_p2 <= {16'h0, cell_src1[15:0]} * {16'h0, cell_src2[31:16]};
            cell_p3 <= {16'h0, cell_src1[31:16]} * {16'h0, cell_src2[15:0]};
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // en_mask bit k is set when cell_en is seen in cycle T+k after the accept cycle T.
    task automatic run_op(input string tag, input logic op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp,
                          input int exp_lat, input logic [31:0] exp_mask);
        int          lat;
        logic [31:0] res;
        logic [31:0] en_mask;
        @(negedge clk);
        check({tag, "_req_ready"}, {31'h0, req_ready}, 32'h1);
        req_valid = 1'b1;
        req_op    = op;
        req_src1  = a;
        req_src2  = b;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op    = ~op;
        req_src1  = ~a;
        req_src2  = 32'h1234_5678;
        lat = 0;
        res = 32'h0;
        en_mask = 32'h0;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            @(negedge clk);
            if (cell_en) en_mask[k] = 1'b1;
            if (rsp_valid) begin
                lat = k;
                res = rsp_result;
            end
        end
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_result"}, res, exp);
        check({tag, "_cell_en"}, en_mask, exp_mask);
        @(negedge clk);
        exp_count++;
        check({tag, "_rsp_valid_drop"}, {31'h0, rsp_valid}, 32'h0);
        check({tag, "_op_count"}, {16'h0, op_count}, exp_count);
    endtask

    initial begin
        int spurious;
        logic [31:0] held;

        // reset state
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_req_ready", {31'h0, req_ready}, 32'h1);
        check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("rst_cell_en", {31'h0, cell_en}, 32'h0);
        check("rst_rsp_result", rsp_result, 32'h0);
        check("rst_cell_src", cell_src1 | cell_src2, 32'h0);
        check("rst_op_count", {16'h0, op_count}, 32'h0);

        // reset during CAP1 of a MULXUU abandons it
        req_valid = 1'b1; req_op = 1'b1; req_src1 = 32'hFFFF_FFFF; req_src2 = 32'hFFFF_FFFF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("abort_issue1_en", {31'h0, cell_en}, 32'h1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("abort_req_ready", {31'h0, req_ready}, 32'h1);
        check("abort_outs_zero", {31'h0, rsp_valid | cell_en} | rsp_result | cell_src1 | cell_src2, 32'h0);
        spurious = 0;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid || cell_en) spurious++;
        end
        check("abort_no_rsp", spurious, 0);
        check("abort_op_count", {16'h0, op_count}, 32'h0);

        // directed vectors: full products hand-computed
        run_op("mul_small",    1'b0, 32'h0001_0002, 32'h0003_0004, 32'h000A_0008, 3, 32'h2);
        run_op("mulxuu_small", 1'b1, 32'h0001_0002, 32'h0003_0004, 32'h0000_0003, 5, 32'hA);
        run_op("mulxuu_ones",  1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5, 32'hA);
        run_op("mul_ones",     1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 3, 32'h2);
        run_op("mul_msb",      1'b0, 32'h8000_0000, 32'h0000_0002, 32'h0000_0000, 3, 32'h2);
        run_op("mulxuu_msb",   1'b1, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 5, 32'hA);
        run_op("mulxuu_mix",   1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0B00_EA4E, 5, 32'hA);

        // back-pressure: result held, new requests ignored, exactly one handshake
        rsp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_op = 1'b0; req_src1 = 32'h0001_0002; req_src2 = 32'h0003_0004;
        @(posedge clk);
        #1 req_valid = 1'b0;
        spurious = 0;
        for (int k = 0; k < 20 && !rsp_valid; k++) @(negedge clk);
        check("stall_rsp_seen", {31'h0, rsp_valid}, 32'h1);
        held = rsp_result;
        check("stall_result", held, 32'h000A_0008);
        for (int i = 0; i < 10; i++) begin
            req_valid = i[0];
            req_src1  = 32'h0000_0005 + i;
            req_src2  = 32'h0000_0007;
            @(negedge clk);
            check("stall_rsp_valid", {31'h0, rsp_valid}, 32'h1);
            check("stall_hold", rsp_result, held);
            check("stall_req_ready", {31'h0, req_ready}, 32'h0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        exp_count++;
        check("release_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("release_op_count", {16'h0, op_count}, exp_count);
        check("release_req_ready", {31'h0, req_ready}, 32'h1);
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid || cell_en) spurious++;
        end
        check("release_no_extra", spurious, 0);
        check("release_count_stable", {16'h0, op_count}, exp_count);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
